serial_adder_fa: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/fa_using_2_ha.sv | 21 ++
 rtl/serial_adder_fa.sv | 129 ++++++++++++
 tb/tb_serial_adder_fa.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fa_using_2_ha.sv
// Gate-level full adder: two half adders
// feeding an OR for the carry.
module fa_using_2_ha (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s  = x ^ y;
  assign h1_c  = x & y;
  assign sum   = h1_s ^ z;
  assign h2_c  = h1_s & z;
  assign carry = h1_c | h2_c;

endmodule

// File: rtl/serial_adder_fa.sv
// Bit-serial adder: one full-adder cell,
// LSB first, registered carry, parallel result.
module serial_adder_fa
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic fa_s;
  logic fa_c;
  logic load;
  logic last;

  fa_using_2_ha u_fa (
    .x     (a_q[0]),
    .y     (b_q[0]),
    .z     (carry_q),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // start is only honoured outside SHIFT
  assign load = start && (state_q != SHIFT);
  assign last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (load) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      r_d     = {fa_s, r_q[WIDTH-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + CNT_ONE;
      if (last) begin
        sum_d  = r_d;
        cout_d = fa_c;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_fa.sv
// Self-checking bench for serial_adder_fa
// at WIDTH 8 (directed) and 2/32 (random).
module tb_serial_adder_fa;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;

  logic       st8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ci8 = 1'b0;
  logic       bz8, dn8, co8;
  logic [7:0] s8;

  logic       st2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ci2 = 1'b0;
  logic       bz2, dn2, co2;
  logic [1:0] s2;

  logic        st32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ci32 = 1'b0;
  logic        bz32, dn32, co32;
  logic [31:0] s32;

  int checks   = 0;
  int failures = 0;

  serial_adder_fa #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8),
    .a(a8), .b(b8), .cin(ci8),
    .busy(bz8), .done(dn8), .sum(s8), .cout(co8)
  );

  serial_adder_fa #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst2_n), .start(st2),
    .a(a2), .b(b2), .cin(ci2),
    .busy(bz2), .done(dn2), .sum(s2), .cout(co2)
  );

  serial_adder_fa #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst2_n), .start(st32),
    .a(a32), .b(b32), .cin(ci32),
    .busy(bz32), .done(dn32), .sum(s32), .cout(co32)
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Model: an accepted add finishes WIDTH edges later
  logic       m_busy, m_done, m_cout;
  logic [7:0] m_sum;
  logic [8:0] m_res;
  int         m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_sum = 0;
      m_cout = 0; m_left = 0; m_res = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        {m_cout, m_sum} = m_res;
      end
    end else begin
      m_done = 0;
      if (st8) begin
        m_res  = {1'b0, a8} + {1'b0, b8} + {8'd0, ci8};
        m_left = 8;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("w8_busy", bz8, m_busy);
    chk("w8_done", dn8, m_done);
    chk("w8_sum", s8, m_sum);
    chk("w8_cout", co8, m_cout);
  end

  task automatic wait_done(input string nm,
                           input logic [8:0] exp);
    int nb;
    bit seen;
    nb = 0;
    seen = 0;
    @(posedge clk);
    #2 st8 = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) chk({nm, "_busy1"}, bz8, 1);
      if (dn8) seen = 1;
      else if (bz8) nb++;
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_lat"}, nb, 8);
    chk({nm, "_res"}, {co8, s8}, exp);
  endtask

  task automatic go8(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic c);
    @(posedge clk);
    #2;
    st8 = 1; a8 = a; b8 = b; ci8 = c;
  endtask

  task automatic main_seq();
    int  nd;
    bit  seen;
    logic [8:0] first;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bz8, 0);
    chk("rst_done", dn8, 0);
    chk("rst_sum", s8, 0);
    chk("rst_cout", co8, 0);
    #1 rst_n = 1;

    go8(8'hFF, 8'h01, 0);
    wait_done("ff01", 9'h100);
    chk("pin_ff01", {m_cout, m_sum}, 9'h100);

    go8(8'h5A, 8'hA5, 1);
    wait_done("5aa5", 9'h100);
    go8(8'h3C, 8'h42, 0);
    wait_done("3c42", 9'h07E);
    chk("pin_3c42", {m_cout, m_sum}, 9'h07E);

    // start held high, operands scrambled
    nd = 0;
    first = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (dn8) begin
        nd++;
        if (nd == 1) first = {co8, s8};
      end
      st8 = 1;
      a8 = (i == 0) ? 8'h01 : 8'($urandom);
      b8 = (i == 0) ? 8'h02 : 8'($urandom);
      ci8 = 0;
    end
    st8 = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dn8) seen = 1;
    end
    chk("hold_first", first, 9'h003);
    chk("hold_ndone", nd, 2);
    chk("hold_tail", seen, 1);

    go8(8'h33, 8'h44, 0);
    wait_done("pre", 9'h077);
    st8 = 1; a8 = 8'h10; b8 = 8'h20; ci8 = 0;
    wait_done("b2b", 9'h030);

    go8(8'h77, 8'h11, 0);
    @(posedge clk);
    #2 st8 = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("ab_busy", bz8, 0);
    chk("ab_done", dn8, 0);
    chk("ab_sum", s8, 0);
    chk("ab_cout", co8, 0);
    #4 rst_n = 1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (dn8) nd++;
    end
    chk("ab_nodone", nd, 0);
    go8(8'h12, 8'h34, 1);
    wait_done("post", 9'h047);
  endtask

  task automatic run_rand2();
    logic [1:0] ra, rb;
    logic       rc;
    logic [2:0] ex;
    int nb;
    bit seen;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      ra = 2'($urandom); rb = 2'($urandom);
      rc = 1'($urandom);
      st2 = 1; a2 = ra; b2 = rb; ci2 = rc;
      ex = {1'b0, ra} + {1'b0, rb} + {2'd0, rc};
      @(posedge clk);
      #2;
      st2 = 0; a2 = ~ra; b2 = ~rb; ci2 = ~rc;
      nb = 0;
      seen = 0;
      for (int j = 0; j < 20 && !seen; j++) begin
        @(negedge clk);
        if (dn2) seen = 1;
        else if (bz2) nb++;
      end
      chk("w2_seen", seen, 1);
      chk("w2_lat", nb, 2);
      chk("w2_res", {co2, s2}, ex);
    end
  endtask

  task automatic run_rand32();
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] ex;
    int nb;
    bit seen;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      ra = $urandom; rb = $urandom;
      if (i == 0) begin ra = '1; rb = '0; end
      rc = (i == 0) ? 1'b1 : 1'($urandom);
      st32 = 1; a32 = ra; b32 = rb; ci32 = rc;
      ex = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      if (i == 0) chk("w32_pin", ex, 33'h1_0000_0000);
      @(posedge clk);
      #2;
      st32 = 0; a32 = ~ra; b32 = ~rb; ci32 = ~rc;
      nb = 0;
      seen = 0;
      for (int j = 0; j < 60 && !seen; j++) begin
        @(negedge clk);
        if (dn32) seen = 1;
        else if (bz32) nb++;
      end
      chk("w32_seen", seen, 1);
      chk("w32_lat", nb, 32);
      chk("w32_res", {co32, s32}, ex);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst2_n = 1;
    fork
      main_seq();
      run_rand2();
      run_rand32();
    join
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
